// File: rtl/is_issue_queue_pkg.sv
// Shared types for the issue stage: renamed instruction, queue entry and sizing constants.
package is_issue_queue_pkg;

    localparam int PRF_WIDTH = 6;
    localparam int PRF_NUM   = 2 ** PRF_WIDTH;
    localparam int IQ_DEPTH  = 8;

    typedef struct packed {
        logic reg_write;
        logic rs1_used;
        logic rs2_used;
    } ctrl_type;

    typedef struct packed {
        ctrl_type               control;
        logic [7:0]             uid;
        logic [PRF_WIDTH-1:0]   rs1_prf;
        logic [PRF_WIDTH-1:0]   rs2_prf;
        logic [PRF_WIDTH-1:0]   rd_prf;
    } ir_is_type;

    typedef struct packed {
        logic      valid;
        logic      rs1_rdy;
        logic      rs2_rdy;
        ir_is_type instr;
    } iq_entry_type;

    function automatic logic tag_hit(input logic v, input logic [PRF_WIDTH-1:0] tag,
                                     input logic [PRF_WIDTH-1:0] prf);
        return v && (tag == prf);
    endfunction

endpackage

// File: rtl/is_issue_queue_busy_table.sv
// Physical-register busy table: two set ports, two clear (wakeup) ports, four lookups that
// see same-cycle wakeups. A tag set and cleared in the same cycle ends up busy.
module iq_busy_table
    import is_issue_queue_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                set_en,
    input  logic [1:0][PRF_WIDTH-1:0] set_prf,
    input  logic [1:0]                clr_en,
    input  logic [1:0][PRF_WIDTH-1:0] clr_prf,
    input  logic [3:0][PRF_WIDTH-1:0] lk_prf,
    output logic [3:0]                lk_rdy
);

    logic [PRF_NUM-1:0] busy;
    logic [PRF_NUM-1:0] busy_next;

    always_comb begin
        busy_next = busy;
        for (int k = 0; k < 2; k++)
            if (clr_en[k]) busy_next[clr_prf[k]] = 1'b0;
        for (int k = 0; k < 2; k++)
            if (set_en[k]) busy_next[set_prf[k]] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy <= '0;
        else       busy <= busy_next;
    end

    always_comb begin
        lk_rdy = '0;
        for (int q = 0; q < 4; q++)
            lk_rdy[q] = (lk_prf[q] == '0) | ~busy[lk_prf[q]]
                      | tag_hit(clr_en[0], clr_prf[0], lk_prf[q])
                      | tag_hit(clr_en[1], clr_prf[1], lk_prf[q]);
    end

endmodule

// File: rtl/is_issue_queue.sv
// Compacting two-wide issue queue: dispatch, wakeup, oldest-first dual select.
// Define IQ_PERF_EN to add the perf_full_cycles / perf_issued counters.
module is_issue_queue
    import is_issue_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       disp_valid_0,
    input  logic                       disp_valid_1,
    input  ir_is_type                  disp_instr_0,
    input  ir_is_type                  disp_instr_1,
    output logic                       is_stall,
    input  logic                       wb_valid_0,
    input  logic                       wb_valid_1,
    input  logic [PRF_WIDTH-1:0]       wb_prf_0,
    input  logic [PRF_WIDTH-1:0]       wb_prf_1,
    output logic                       iss_valid_0,
    output logic                       iss_valid_1,
    output ir_is_type                  iss_instr_0,
    output ir_is_type                  iss_instr_1,
    output logic [$clog2(DEPTH):0]     iq_count
`ifdef IQ_PERF_EN
    ,
    output logic [31:0]                perf_full_cycles,
    output logic [31:0]                perf_issued
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(DEPTH);

    iq_entry_type q      [DEPTH];
    iq_entry_type q_next [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] wr_ptr;

    logic          found0, found1;
    logic [IW-1:0] sel0, sel1;
    logic          accept, dep0;
    logic [3:0]    lk_rdy;
    logic          r0_1, r0_2, r1_1, r1_2;

    // Stall looks only at the registered count; this cycle's issues are not credited.
    assign is_stall = (count_q > CW'(DEPTH - 2));
    assign accept   = disp_valid_0 & ~is_stall & ~flush;
    assign dep0     = disp_instr_0.control.reg_write & (disp_instr_0.rd_prf != '0);

    iq_busy_table u_busy (
        .clk     (clk),
        .reset   (reset),
        .set_en  ({accept & disp_valid_1 & disp_instr_1.control.reg_write & (disp_instr_1.rd_prf != '0),
                   accept & dep0}),
        .set_prf ({disp_instr_1.rd_prf, disp_instr_0.rd_prf}),
        .clr_en  ({wb_valid_1, wb_valid_0}),
        .clr_prf ({wb_prf_1, wb_prf_0}),
        .lk_prf  ({disp_instr_1.rs2_prf, disp_instr_1.rs1_prf,
                   disp_instr_0.rs2_prf, disp_instr_0.rs1_prf}),
        .lk_rdy  (lk_rdy)
    );

    // The younger slot cannot see the older slot's destination as ready.
    assign r0_1 = ~disp_instr_0.control.rs1_used | lk_rdy[0];
    assign r0_2 = ~disp_instr_0.control.rs2_used | lk_rdy[1];
    assign r1_1 = ~disp_instr_1.control.rs1_used
                | (lk_rdy[2] & ~(dep0 & (disp_instr_1.rs1_prf == disp_instr_0.rd_prf)));
    assign r1_2 = ~disp_instr_1.control.rs2_used
                | (lk_rdy[3] & ~(dep0 & (disp_instr_1.rs2_prf == disp_instr_0.rd_prf)));

    always_comb begin
        found0 = 1'b0;
        found1 = 1'b0;
        sel0   = '0;
        sel1   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q[i].valid && q[i].rs1_rdy && q[i].rs2_rdy) begin
                if (!found0) begin
                    found0 = 1'b1;
                    sel0   = IW'(i);
                end else if (!found1) begin
                    found1 = 1'b1;
                    sel1   = IW'(i);
                end
            end
        end
    end

    assign iss_valid_0 = found0;
    assign iss_valid_1 = found1;
    assign iss_instr_0 = q[sel0].instr;
    assign iss_instr_1 = q[sel1].instr;
    assign iq_count    = count_q;

    // Survivors shift down in age order and pick up this cycle's wakeups; new pair appended.
    always_comb begin
        wr_ptr = '0;
        for (int j = 0; j < DEPTH; j++) q_next[j] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q[i].valid && !(found0 && sel0 == IW'(i)) && !(found1 && sel1 == IW'(i))) begin
                q_next[wr_ptr[IW-1:0]]         = q[i];
                q_next[wr_ptr[IW-1:0]].rs1_rdy = q[i].rs1_rdy
                    | tag_hit(wb_valid_0, wb_prf_0, q[i].instr.rs1_prf)
                    | tag_hit(wb_valid_1, wb_prf_1, q[i].instr.rs1_prf);
                q_next[wr_ptr[IW-1:0]].rs2_rdy = q[i].rs2_rdy
                    | tag_hit(wb_valid_0, wb_prf_0, q[i].instr.rs2_prf)
                    | tag_hit(wb_valid_1, wb_prf_1, q[i].instr.rs2_prf);
                wr_ptr = wr_ptr + CW'(1);
            end
        end
        if (accept) begin
            q_next[wr_ptr[IW-1:0]].valid   = 1'b1;
            q_next[wr_ptr[IW-1:0]].rs1_rdy = r0_1;
            q_next[wr_ptr[IW-1:0]].rs2_rdy = r0_2;
            q_next[wr_ptr[IW-1:0]].instr   = disp_instr_0;
            wr_ptr = wr_ptr + CW'(1);
            if (disp_valid_1) begin
                q_next[wr_ptr[IW-1:0]].valid   = 1'b1;
                q_next[wr_ptr[IW-1:0]].rs1_rdy = r1_1;
                q_next[wr_ptr[IW-1:0]].rs2_rdy = r1_2;
                q_next[wr_ptr[IW-1:0]].instr   = disp_instr_1;
                wr_ptr = wr_ptr + CW'(1);
            end
        end
        if (flush) begin
            for (int j = 0; j < DEPTH; j++) q_next[j] = '0;
            wr_ptr = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < DEPTH; j++) q[j] <= '0;
            count_q <= '0;
        end else begin
            for (int j = 0; j < DEPTH; j++) q[j] <= q_next[j];
            count_q <= wr_ptr;
        end
    end

`ifdef IQ_PERF_EN
    logic [32:0] issued_sum;
    assign issued_sum = {1'b0, perf_issued} + 33'(found0) + 33'(found1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_full_cycles <= '0;
            perf_issued      <= '0;
        end else begin
            if (is_stall && perf_full_cycles != 32'hFFFF_FFFF)
                perf_full_cycles <= perf_full_cycles + 32'd1;
            perf_issued <= issued_sum[32] ? 32'hFFFF_FFFF : issued_sum[31:0];
        end
    end
`else
    // Counters absent; the queue datapath above is identical either way.
`endif

endmodule

// File: tb/tb_is_issue_queue.sv
// Directed scenarios then random traffic, checked against a queue-level reference model.
module tb_is_issue_queue;
  import is_issue_queue_pkg::*;

  localparam int CW = $clog2(IQ_DEPTH) + 1;

  typedef struct {
    ir_is_type ins;
    bit        r1;
    bit        r2;
  } m_ent_t;

  logic clk = 1'b0;
  logic reset, flush, disp_valid_0, disp_valid_1, is_stall;
  logic wb_valid_0, wb_valid_1, iss_valid_0, iss_valid_1;
  ir_is_type disp_instr_0, disp_instr_1, iss_instr_0, iss_instr_1;
  logic [PRF_WIDTH-1:0] wb_prf_0, wb_prf_1;
  logic [CW-1:0] iq_count;
`ifdef IQ_PERF_EN
  logic [31:0] perf_full_cycles, perf_issued;
`endif

  int n_pass = 0;
  int n_checks = 0;
  logic [7:0] uid_ctr = 8'd0;
  m_ent_t mq[$];
  bit busy_m[PRF_NUM];

  always #5 clk = ~clk;

  is_issue_queue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid_0(disp_valid_0), .disp_valid_1(disp_valid_1),
    .disp_instr_0(disp_instr_0), .disp_instr_1(disp_instr_1),
    .is_stall(is_stall),
    .wb_valid_0(wb_valid_0), .wb_valid_1(wb_valid_1),
    .wb_prf_0(wb_prf_0), .wb_prf_1(wb_prf_1),
    .iss_valid_0(iss_valid_0), .iss_valid_1(iss_valid_1),
    .iss_instr_0(iss_instr_0), .iss_instr_1(iss_instr_1),
    .iq_count(iq_count)
`ifdef IQ_PERF_EN
    , .perf_full_cycles(perf_full_cycles), .perf_issued(perf_issued)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic ir_is_type mk(input bit rw, input bit u1, input bit u2,
                                   input int rd, input int s1, input int s2);
    ir_is_type r;
    uid_ctr = uid_ctr + 8'd1;
    r.control.reg_write = rw;
    r.control.rs1_used  = u1;
    r.control.rs2_used  = u2;
    r.uid     = uid_ctr;
    r.rd_prf  = PRF_WIDTH'(rd);
    r.rs1_prf = PRF_WIDTH'(s1);
    r.rs2_prf = PRF_WIDTH'(s2);
    return r;
  endfunction

  function automatic ir_is_type rand_instr();
    return mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
  endfunction

  function automatic bit hit(input logic [PRF_WIDTH-1:0] p, input bit w0,
                             input logic [PRF_WIDTH-1:0] p0, input bit w1,
                             input logic [PRF_WIDTH-1:0] p1);
    return (w0 && p0 == p) || (w1 && p1 == p);
  endfunction

  // Reference: spec-level queue of {instr, src ready bits} plus a busy bit per register.
  task automatic model_step(input bit fl, input bit dv0, input bit dv1,
                            input ir_is_type a, input ir_is_type b,
                            input bit w0, input logic [PRF_WIDTH-1:0] p0,
                            input bit w1, input logic [PRF_WIDTH-1:0] p1);
    bit accept, dep0;
    int e0, e1;
    m_ent_t n;
    accept = dv0 && !fl && !((IQ_DEPTH - mq.size()) < 2);
    dep0 = a.control.reg_write && a.rd_prf != 0;
    e0 = -1;
    e1 = -1;
    foreach (mq[i])
      if (mq[i].r1 && mq[i].r2) begin
        if (e0 < 0) e0 = i;
        else if (e1 < 0) e1 = i;
      end
    if (e1 >= 0) mq.delete(e1);
    if (e0 >= 0) mq.delete(e0);
    foreach (mq[i]) begin
      mq[i].r1 = mq[i].r1 || hit(mq[i].ins.rs1_prf, w0, p0, w1, p1);
      mq[i].r2 = mq[i].r2 || hit(mq[i].ins.rs2_prf, w0, p0, w1, p1);
    end
    if (fl) mq.delete();
    if (accept) begin
      n.ins = a;
      n.r1 = !a.control.rs1_used || a.rs1_prf == 0 || !busy_m[a.rs1_prf] || hit(a.rs1_prf, w0, p0, w1, p1);
      n.r2 = !a.control.rs2_used || a.rs2_prf == 0 || !busy_m[a.rs2_prf] || hit(a.rs2_prf, w0, p0, w1, p1);
      mq.push_back(n);
      if (dv1) begin
        n.ins = b;
        n.r1 = !b.control.rs1_used || ((b.rs1_prf == 0 || !busy_m[b.rs1_prf] || hit(b.rs1_prf, w0, p0, w1, p1))
                                       && !(dep0 && b.rs1_prf == a.rd_prf));
        n.r2 = !b.control.rs2_used || ((b.rs2_prf == 0 || !busy_m[b.rs2_prf] || hit(b.rs2_prf, w0, p0, w1, p1))
                                       && !(dep0 && b.rs2_prf == a.rd_prf));
        mq.push_back(n);
      end
    end
    if (w0) busy_m[p0] = 1'b0;
    if (w1) busy_m[p1] = 1'b0;
    if (accept && dep0) busy_m[a.rd_prf] = 1'b1;
    if (accept && dv1 && b.control.reg_write && b.rd_prf != 0) busy_m[b.rd_prf] = 1'b1;
  endtask

  task automatic model_reset();
    mq.delete();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
  endtask

  task automatic expect_outputs();
    int e0, e1;
    e0 = -1;
    e1 = -1;
    foreach (mq[i])
      if (mq[i].r1 && mq[i].r2) begin
        if (e0 < 0) e0 = i;
        else if (e1 < 0) e1 = i;
      end
    chk("iq_count", 64'(iq_count), 64'(mq.size()));
    chk("is_stall", 64'(is_stall), 64'((IQ_DEPTH - mq.size()) < 2));
    chk("iss_valid_0", 64'(iss_valid_0), 64'(e0 >= 0));
    chk("iss_valid_1", 64'(iss_valid_1), 64'(e1 >= 0));
    if (e0 >= 0) chk("iss_instr_0", 64'(iss_instr_0), 64'(mq[e0].ins));
    if (e1 >= 0) chk("iss_instr_1", 64'(iss_instr_1), 64'(mq[e1].ins));
  endtask

  task automatic drive(input bit fl, input bit dv0, input bit dv1,
                       input ir_is_type a, input ir_is_type b,
                       input bit w0, input logic [PRF_WIDTH-1:0] p0,
                       input bit w1, input logic [PRF_WIDTH-1:0] p1);
    flush = fl;
    disp_valid_0 = dv0;
    disp_valid_1 = dv1;
    disp_instr_0 = a;
    disp_instr_1 = b;
    wb_valid_0 = w0;
    wb_prf_0 = p0;
    wb_valid_1 = w1;
    wb_prf_1 = p1;
  endtask

  // One clock: check current outputs, drive inputs for the next edge, advance the model.
  task automatic cycle(input bit fl, input bit dv0, input bit dv1,
                       input ir_is_type a, input ir_is_type b,
                       input bit w0, input logic [PRF_WIDTH-1:0] p0,
                       input bit w1, input logic [PRF_WIDTH-1:0] p1);
    @(negedge clk);
    expect_outputs();
    drive(fl, dv0, dv1, a, b, w0, p0, w1, p1);
    model_step(fl, dv0, dv1, a, b, w0, p0, w1, p1);
  endtask

  task automatic idle();
    cycle(0, 0, 0, '0, '0, 0, '0, 0, '0);
  endtask

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ir_is_type ia, ib, ic, r_first;
    bit fl, dv0, dv1, w0, w1;
    logic [PRF_WIDTH-1:0] p0, p1;

    reset = 1'b1;
    drive(0, 0, 0, '0, '0, 0, '0, 0, '0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_count", 64'(iq_count), 64'd0);
    chk("rst_stall", 64'(is_stall), 64'd0);
    chk("rst_iss_v0", 64'(iss_valid_0), 64'd0);
    chk("rst_iss_v1", 64'(iss_valid_1), 64'd0);
    reset = 1'b0;

    // Independent pair issues together on the next cycle.
    ia = mk(1, 0, 0, 3, 0, 0);
    ib = mk(1, 1, 1, 4, 0, 0);
    cycle(0, 1, 1, ia, ib, 0, '0, 0, '0);
    peek();
    chk("t1_iss0_uid", 64'(iss_instr_0.uid), 64'(ia.uid));
    chk("t1_iss1_uid", 64'(iss_instr_1.uid), 64'(ib.uid));
    chk("t1_count", 64'(iq_count), 64'd2);
    idle();
    peek();
    chk("t1_drain", 64'(iq_count), 64'd0);

    // Younger slot reading the older slot's destination waits for writeback.
    ia = mk(1, 0, 0, 5, 0, 0);
    ib = mk(0, 1, 0, 0, 5, 0);
    cycle(0, 1, 1, ia, ib, 0, '0, 0, '0);
    peek();
    chk("t2_iss0_uid", 64'(iss_instr_0.uid), 64'(ia.uid));
    chk("t2_iss1_blocked", 64'(iss_valid_1), 64'd0);
    idle();
    peek();
    chk("t2_wait_v0", 64'(iss_valid_0), 64'd0);
    chk("t2_wait_count", 64'(iq_count), 64'd1);
    cycle(0, 0, 0, '0, '0, 1, PRF_WIDTH'(5), 0, '0);
    peek();
    chk("t2_wake_v0", 64'(iss_valid_0), 64'd1);
    chk("t2_wake_uid", 64'(iss_instr_0.uid), 64'(ib.uid));
    idle();

    // Fill to seven entries blocked on P9, then wake them.
    ia = mk(1, 0, 0, 9, 0, 0);
    r_first = mk(0, 1, 0, 0, 9, 0);
    cycle(0, 1, 1, ia, r_first, 0, '0, 0, '0);
    for (int k = 0; k < 3; k++)
      cycle(0, 1, 1, mk(0, 1, 0, 0, 9, 0), mk(0, 0, 1, 0, 0, 9), 0, '0, 0, '0);
    peek();
    chk("t3_full_count", 64'(iq_count), 64'd7);
    chk("t3_full_stall", 64'(is_stall), 64'd1);
    cycle(0, 1, 1, mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0), 1, PRF_WIDTH'(9), 0, '0);
    peek();
    chk("t3_rejected_count", 64'(iq_count), 64'd7);
    chk("t3_still_stall", 64'(is_stall), 64'd1);
    chk("t3_oldest_uid", 64'(iss_instr_0.uid), 64'(r_first.uid));
    idle();
    peek();
    chk("t3_after_count", 64'(iq_count), 64'd5);
    chk("t3_after_stall", 64'(is_stall), 64'd0);
    repeat (4) idle();

    // Wakeup in the same cycle as dispatch of its consumer.
    cycle(0, 1, 0, mk(1, 0, 0, 7, 0, 0), '0, 0, '0, 0, '0);
    ic = mk(0, 0, 1, 0, 0, 7);
    cycle(0, 1, 0, ic, '0, 1, PRF_WIDTH'(7), 0, '0);
    peek();
    chk("t4_bypass_v0", 64'(iss_valid_0), 64'd1);
    chk("t4_bypass_uid", 64'(iss_instr_0.uid), 64'(ic.uid));
    idle();

    // Flush with five entries pending and a pair arriving.
    cycle(0, 1, 1, mk(1, 0, 0, 11, 0, 0), mk(0, 1, 0, 0, 11, 0), 0, '0, 0, '0);
    cycle(0, 1, 1, mk(0, 1, 0, 0, 11, 0), mk(0, 1, 0, 0, 11, 0), 0, '0, 0, '0);
    cycle(0, 1, 1, mk(0, 1, 0, 0, 11, 0), mk(0, 1, 0, 0, 11, 0), 0, '0, 0, '0);
    peek();
    chk("t5_pre_count", 64'(iq_count), 64'd5);
    cycle(1, 1, 1, mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0), 0, '0, 0, '0);
    peek();
    chk("t5_flush_count", 64'(iq_count), 64'd0);
    chk("t5_flush_v0", 64'(iss_valid_0), 64'd0);
    idle();

    // Asynchronous reset with entries pending.
    cycle(0, 1, 1, mk(1, 0, 0, 12, 0, 0), mk(0, 1, 0, 0, 12, 0), 0, '0, 0, '0);
    cycle(0, 1, 1, mk(0, 0, 0, 0, 0, 0), mk(0, 1, 0, 0, 12, 0), 0, '0, 0, '0);
    @(posedge clk);
    #2;
    chk("t6_pre_v0", 64'(iss_valid_0), 64'd1);
    chk("t6_pre_count", 64'(iq_count), 64'd3);
    reset = 1'b1;
    #1;
    chk("t6_rst_v0", 64'(iss_valid_0), 64'd0);
    chk("t6_rst_v1", 64'(iss_valid_1), 64'd0);
    chk("t6_rst_count", 64'(iq_count), 64'd0);
    chk("t6_rst_stall", 64'(is_stall), 64'd0);
    model_reset();
    @(negedge clk);
    drive(0, 0, 0, '0, '0, 0, '0, 0, '0);
    reset = 1'b0;
    ic = mk(0, 1, 0, 0, 12, 0);
    cycle(0, 1, 0, ic, '0, 0, '0, 0, '0);
    peek();
    chk("t6_busy_clear_v0", 64'(iss_valid_0), 64'd1);
    chk("t6_busy_clear_uid", 64'(iss_instr_0.uid), 64'(ic.uid));

    // Random traffic.
    repeat (400) begin
      fl = ($urandom_range(0, 29) == 0);
      dv0 = ($urandom_range(0, 2) != 0);
      dv1 = dv0 && ($urandom_range(0, 1) == 1);
      w0 = ($urandom_range(0, 1) == 1);
      w1 = ($urandom_range(0, 1) == 1);
      p0 = PRF_WIDTH'($urandom_range(0, 15));
      p1 = PRF_WIDTH'($urandom_range(0, 15));
      ia = rand_instr();
      ib = rand_instr();
      cycle(fl, dv0, dv1, ia, ib, w0, p0, w1, p1);
    end
    repeat (3) idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
